// File: rtl/regs_arbiter_if.sv
// Bundle of both requester ports and the register-file access port.
// The arbiter takes the slave view; requesters and the register file take the master view.
interface regs_arbiter_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 8
);
  logic              rq0_req;
  logic              rq0_write;
  logic [ADDR_W-1:0] rq0_addr;
  logic [DATA_W-1:0] rq0_wdata;
  logic              rq0_ack;
  logic [DATA_W-1:0] rq0_rdata;

  logic              rq1_req;
  logic              rq1_write;
  logic [ADDR_W-1:0] rq1_addr;
  logic [DATA_W-1:0] rq1_wdata;
  logic              rq1_ack;
  logic [DATA_W-1:0] rq1_rdata;

  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_write;
  logic [DATA_W-1:0] data_read;

  modport master (
    output rq0_req, rq0_write, rq0_addr, rq0_wdata,
    input  rq0_ack, rq0_rdata,
    output rq1_req, rq1_write, rq1_addr, rq1_wdata,
    input  rq1_ack, rq1_rdata,
    input  read, write, addr, data_write,
    output data_read
  );

  modport slave (
    input  rq0_req, rq0_write, rq0_addr, rq0_wdata,
    output rq0_ack, rq0_rdata,
    input  rq1_req, rq1_write, rq1_addr, rq1_wdata,
    output rq1_ack, rq1_rdata,
    output read, write, addr, data_write,
    input  data_read
  );
endinterface

// File: rtl/regs_arbiter.sv
// Two-requester round-robin arbiter owning the PWM register file's single access port.
// One full transaction at a time: IDLE -> STROBE -> (CAPTURE) -> DONE.
module regs_arbiter #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 8
) (
  input logic           clk,
  input logic           rst_n,
  regs_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StStrobe, StCapture, StDone} state_e;

  state_e            r_state;
  logic              r_owner;
  logic              r_last;
  logic              r_dir;
  logic              r_read;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_ack0;
  logic              r_ack1;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  logic w_any_req;
  logic w_grant1;

  // Requester 1 wins when alone, or on contention when requester 0 was served last.
  assign w_any_req = bus.rq0_req | bus.rq1_req;
  assign w_grant1  = (bus.rq1_req & ~bus.rq0_req) | (bus.rq1_req & bus.rq0_req & ~r_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_owner  <= 1'b0;
      r_last   <= 1'b1;
      r_dir    <= 1'b0;
      r_read   <= 1'b0;
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_any_req) begin
            r_owner <= w_grant1;
            r_last  <= w_grant1;
            if (w_grant1) begin
              r_dir   <= bus.rq1_write;
              r_read  <= ~bus.rq1_write;
              r_write <= bus.rq1_write;
              r_addr  <= bus.rq1_addr;
              r_wdata <= bus.rq1_wdata;
            end else begin
              r_dir   <= bus.rq0_write;
              r_read  <= ~bus.rq0_write;
              r_write <= bus.rq0_write;
              r_addr  <= bus.rq0_addr;
              r_wdata <= bus.rq0_wdata;
            end
            r_state <= StStrobe;
          end
        end
        StStrobe: begin
          r_read  <= 1'b0;
          r_write <= 1'b0;
          if (r_dir) begin
            r_ack0  <= ~r_owner;
            r_ack1  <= r_owner;
            r_state <= StDone;
          end else begin
            r_state <= StCapture;
          end
        end
        StCapture: begin
          if (r_owner) begin
            r_rdata1 <= bus.data_read;
          end else begin
            r_rdata0 <= bus.data_read;
          end
          r_ack0  <= ~r_owner;
          r_ack1  <= r_owner;
          r_state <= StDone;
        end
        StDone: begin
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.read       = r_read;
  assign bus.write      = r_write;
  assign bus.addr       = r_addr;
  assign bus.data_write = r_wdata;
  assign bus.rq0_ack    = r_ack0;
  assign bus.rq1_ack    = r_ack1;
  assign bus.rq0_rdata  = r_rdata0;
  assign bus.rq1_rdata  = r_rdata1;

endmodule

// File: tb/tb_regs_arbiter.sv
// Directed bench for regs_arbiter with a small registered register-file model.
module tb_regs_arbiter;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 8;

  logic clk;
  logic rst_n;

  regs_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  regs_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DATA_W-1:0] mem [2**ADDR_W];

  int errors;
  int checks;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: write on strobe, read data registered one cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.write) mem[bus.addr] <= bus.data_write;
    bus.data_read <= bus.read ? mem[bus.addr] : '0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.rq0_req = 1'b0; bus.rq0_write = 1'b0; bus.rq0_addr = '0; bus.rq0_wdata = '0;
    bus.rq1_req = 1'b0; bus.rq1_write = 1'b0; bus.rq1_addr = '0; bus.rq1_wdata = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_read"},  {31'd0, bus.read}, 32'd0);
    check({tag, "_write"}, {31'd0, bus.write}, 32'd0);
    check({tag, "_addr"},  {26'd0, bus.addr}, 32'd0);
    check({tag, "_dw"},    {24'd0, bus.data_write}, 32'd0);
    check({tag, "_ack0"},  {31'd0, bus.rq0_ack}, 32'd0);
    check({tag, "_ack1"},  {31'd0, bus.rq1_ack}, 32'd0);
    check({tag, "_rd0"},   {24'd0, bus.rq0_rdata}, 32'd0);
    check({tag, "_rd1"},   {24'd0, bus.rq1_rdata}, 32'd0);
  endtask

  initial begin
    int order [8];
    int n_ack;
    int n_strobe;

    errors = 0;
    checks = 0;
    for (int i = 0; i < 2**ADDR_W; i++) mem[i] = '0;
    mem[6'h0D] = 8'hC3;
    bus.data_read = '0;
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // rq0 write 0x00 = 0x5A
    bus.rq0_req = 1'b1; bus.rq0_write = 1'b1; bus.rq0_addr = 6'h00; bus.rq0_wdata = 8'h5A;
    tick();
    check("w_strobe", {31'd0, bus.write}, 32'd1);
    check("w_noread", {31'd0, bus.read}, 32'd0);
    check("w_addr", {26'd0, bus.addr}, 32'h00);
    check("w_dw", {24'd0, bus.data_write}, 32'h5A);
    bus.rq0_req = 1'b0;
    tick();
    check("w_ack0", {31'd0, bus.rq0_ack}, 32'd1);
    check("w_ack1", {31'd0, bus.rq1_ack}, 32'd0);
    check("w_mem", {24'd0, mem[6'h00]}, 32'h5A);
    tick();
    check("w_ack0_off", {31'd0, bus.rq0_ack}, 32'd0);

    // rq1 read 0x0D returns 0xC3
    bus.rq1_req = 1'b1; bus.rq1_write = 1'b0; bus.rq1_addr = 6'h0D;
    tick();
    check("r_strobe", {31'd0, bus.read}, 32'd1);
    check("r_nowrite", {31'd0, bus.write}, 32'd0);
    check("r_addr", {26'd0, bus.addr}, 32'h0D);
    bus.rq1_req = 1'b0;
    tick();
    check("r_cap_noack", {31'd0, bus.rq1_ack}, 32'd0);
    check("r_cap_noread", {31'd0, bus.read}, 32'd0);
    tick();
    check("r_ack1", {31'd0, bus.rq1_ack}, 32'd1);
    check("r_rd1", {24'd0, bus.rq1_rdata}, 32'hC3);
    check("r_ack0", {31'd0, bus.rq0_ack}, 32'd0);
    tick();

    // Continuous contention for four transactions: order 0,1,0,1
    bus.rq0_req = 1'b1; bus.rq0_write = 1'b1; bus.rq0_addr = 6'h01; bus.rq0_wdata = 8'h11;
    bus.rq1_req = 1'b1; bus.rq1_write = 1'b1; bus.rq1_addr = 6'h02; bus.rq1_wdata = 8'h22;
    n_ack = 0;
    n_strobe = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      check("rr_overlap", {31'd0, bus.read & bus.write}, 32'd0);
      check("rr_dual_ack", {31'd0, bus.rq0_ack & bus.rq1_ack}, 32'd0);
      if (bus.read | bus.write) n_strobe++;
      if (bus.rq0_ack | bus.rq1_ack) begin
        if (n_ack < 8) order[n_ack] = bus.rq1_ack ? 1 : 0;
        n_ack++;
        if (n_ack == 4) begin
          bus.rq0_req = 1'b0;
          bus.rq1_req = 1'b0;
        end
      end
    end
    check("rr_acks", n_ack, 32'd4);
    check("rr_strobes", n_strobe, 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("rr_order%0d", i), order[i], i % 2);
    check("rr_mem1", {24'd0, mem[6'h01]}, 32'h11);
    check("rr_mem2", {24'd0, mem[6'h02]}, 32'h22);

    // Fields change and req drops after the winning edge
    bus.rq0_req = 1'b1; bus.rq0_write = 1'b1; bus.rq0_addr = 6'h03; bus.rq0_wdata = 8'h33;
    tick();
    bus.rq0_addr = 6'h3F; bus.rq0_wdata = 8'hFF; bus.rq0_req = 1'b0;
    check("lat_addr", {26'd0, bus.addr}, 32'h03);
    check("lat_dw", {24'd0, bus.data_write}, 32'h33);
    tick();
    check("lat_ack0", {31'd0, bus.rq0_ack}, 32'd1);
    check("lat_mem3", {24'd0, mem[6'h03]}, 32'h33);
    check("lat_mem3f", {24'd0, mem[6'h3F]}, 32'h00);
    tick();

    // Reset during the read strobe
    bus.rq0_req = 1'b1; bus.rq0_write = 1'b0; bus.rq0_addr = 6'h0D;
    tick();
    check("mr_strobe", {31'd0, bus.read}, 32'd1);
    rst_n = 1'b0;
    bus.rq0_req = 1'b0;
    #1;
    check_reset_outputs("mr");
    tick();
    check("mr_noack0", {31'd0, bus.rq0_ack}, 32'd0);
    rst_n = 1'b1;
    bus.rq0_req = 1'b1; bus.rq0_write = 1'b1; bus.rq0_addr = 6'h05; bus.rq0_wdata = 8'h55;
    bus.rq1_req = 1'b1; bus.rq1_write = 1'b0; bus.rq1_addr = 6'h0D;
    tick();
    check("mr_win_write", {31'd0, bus.write}, 32'd1);
    check("mr_win_addr", {26'd0, bus.addr}, 32'h05);
    bus.rq0_req = 1'b0; bus.rq1_req = 1'b0;
    tick();
    check("mr_ack0", {31'd0, bus.rq0_ack}, 32'd1);
    check("mr_ack1", {31'd0, bus.rq1_ack}, 32'd0);
    tick();

    // rq0 holds req across its ack: next strobe two cycles after the ack
    bus.rq0_req = 1'b1; bus.rq0_write = 1'b1; bus.rq0_addr = 6'h04; bus.rq0_wdata = 8'h44;
    tick();
    check("hold_s1", {31'd0, bus.write}, 32'd1);
    tick();
    check("hold_ack", {31'd0, bus.rq0_ack}, 32'd1);
    tick();
    check("hold_gap", {31'd0, bus.write}, 32'd0);
    check("hold_gap_ack", {31'd0, bus.rq0_ack}, 32'd0);
    tick();
    check("hold_s2", {31'd0, bus.write}, 32'd1);
    bus.rq0_req = 1'b0;
    tick();
    check("hold_ack2", {31'd0, bus.rq0_ack}, 32'd1);
    tick();
    tick();
    check("hold_done", {31'd0, bus.write | bus.read}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
